// File: rtl/apb_pkg.sv
// ============================================================================
// apb_pkg : state encoding and response codes for the APB master
// Revision: 1.0
// ============================================================================
`default_nettype none

package apb_pkg;

  typedef enum logic [1:0] {
    APB_ST_IDLE   = 2'd0,
    APB_ST_SETUP  = 2'd1,
    APB_ST_ACCESS = 2'd2,
    APB_ST_RESP   = 2'd3
  } apb_master_state_t;

  localparam logic APB_RSP_OK  = 1'b0;
  localparam logic APB_RSP_ERR = 1'b1;

endpackage

`default_nettype wire

// File: rtl/apb_master.sv
// ============================================================================
// apb_master : single-outstanding APB initiator with bounded PREADY wait
// Revision: 1.0
// ============================================================================
`default_nettype none

module apb_master
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  apb_clock,
  input  logic                  apb_ares,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic                  cmd_prot,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  apb_psel,
  output logic                  apb_penable,
  output logic                  apb_pwrite,
  output logic [ADDR_WIDTH-1:0] apb_addr,
  output logic [DATA_WIDTH-1:0] apb_wdata,
  output logic                  apb_prot,
  input  logic [DATA_WIDTH-1:0] apb_rdata,
  input  logic                  apb_pready,
  input  logic                  apb_slverror
);

  localparam logic [1:0] S_IDLE   = APB_ST_IDLE;
  localparam logic [1:0] S_SETUP  = APB_ST_SETUP;
  localparam logic [1:0] S_ACCESS = APB_ST_ACCESS;
  localparam logic [1:0] S_RESP   = APB_ST_RESP;

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam int CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  generate
    if (DATA_WIDTH == 0) begin : g_bad_data_width
      $error("apb_master: DATA_WIDTH must be non-zero");
    end
    if (ADDR_WIDTH == 0) begin : g_bad_addr_width
      $error("apb_master: ADDR_WIDTH must be non-zero");
    end
  endgenerate

  logic [1:0]            state_q,     state_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic                  pwrite_q,    pwrite_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
  logic                  prot_q,      prot_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pwrite_d    = pwrite_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    prot_d      = prot_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          pwrite_d = cmd_write;
          addr_d   = cmd_addr;
          wdata_d  = cmd_wdata;
          prot_d   = cmd_prot;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        // A completing slave wins over a timeout expiring in the same cycle.
        if (apb_pready) begin
          rsp_rdata_d = pwrite_q ? '0 : apb_rdata;
          rsp_error_d = apb_slverror;
          state_d     = S_RESP;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          rsp_rdata_d = '0;
          rsp_error_d = APB_RSP_ERR;
          state_d     = S_RESP;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge apb_clock) begin
    if (apb_ares) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pwrite_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      prot_q      <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= APB_RSP_OK;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pwrite_q    <= pwrite_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      prot_q      <= prot_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign rsp_valid   = (state_q == S_RESP);
  assign apb_psel    = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign apb_penable = (state_q == S_ACCESS);
  assign apb_pwrite  = pwrite_q;
  assign apb_addr    = addr_q;
  assign apb_wdata   = wdata_q;
  assign apb_prot    = prot_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master.sv
// ============================================================================
// tb_apb_master : randomized self-checking bench for apb_master
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_apb_master;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          apb_ares = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_prot = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          apb_psel;
  logic          apb_penable;
  logic          apb_pwrite;
  logic [AW-1:0] apb_addr;
  logic [DW-1:0] apb_wdata;
  logic          apb_prot;
  logic [DW-1:0] apb_rdata = '0;
  logic          apb_pready = 1'b0;
  logic          apb_slverror = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  apb_master #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .apb_clock   (clk),
    .apb_ares    (apb_ares),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_prot    (cmd_prot),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .apb_psel    (apb_psel),
    .apb_penable (apb_penable),
    .apb_pwrite  (apb_pwrite),
    .apb_addr    (apb_addr),
    .apb_wdata   (apb_wdata),
    .apb_prot    (apb_prot),
    .apb_rdata   (apb_rdata),
    .apb_pready  (apb_pready),
    .apb_slverror(apb_slverror)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and play the slave: it raises PREADY on access cycle
  // number `waits` (0-based), or never if the timeout fires first.
  task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input bit prot, input int waits, input logic [DW-1:0] rdata,
                         input bit serr, input int bp);
    bit            timed_out;
    int            exp_acc;
    logic          exp_err;
    logic [DW-1:0] exp_rd;
    int            n;
    int            k;

    timed_out = (waits >= TO);
    exp_acc   = timed_out ? TO : waits + 1;
    exp_err   = timed_out ? 1'b1 : serr;
    exp_rd    = (timed_out || wr) ? '0 : rdata;

    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("cmd_ready_idle", cmd_ready, 1);

    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_prot  = prot;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_write = ~wr;
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;
    cmd_prot  = ~prot;

    @(negedge clk);
    check_eq("setup_psel", {apb_psel, apb_penable, cmd_ready, rsp_valid}, 4'b1000);
    check_eq("setup_ctrl", {apb_pwrite, apb_prot}, {wr, prot});
    check_eq("setup_addr", apb_addr, addr);
    check_eq("setup_wdata", apb_wdata, wdata);

    @(negedge clk);
    k = 0;
    while (apb_psel && apb_penable && k < 40) begin
      check_eq("access_hold", {apb_pwrite, apb_prot, apb_addr, cmd_ready},
               {wr, prot, addr, 1'b0});
      check_eq("access_wdata", apb_wdata, wdata);
      apb_pready   = (k == waits);
      apb_rdata    = (k == waits) ? rdata : $urandom;
      apb_slverror = (k == waits) ? serr : 1'($urandom);
      k++;
      @(negedge clk);
    end
    apb_pready   = 1'b0;
    apb_slverror = 1'b0;
    apb_rdata    = $urandom;
    check_eq("access_cycles", k, exp_acc);

    check_eq("resp_ctrl", {rsp_valid, apb_psel, apb_penable, cmd_ready}, 4'b1000);
    check_eq("resp_rdata", rsp_rdata, exp_rd);
    check_eq("resp_error", rsp_error, exp_err);

    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check_eq("bp_hold", {rsp_valid, cmd_ready, rsp_error}, {2'b10, exp_err});
      check_eq("bp_rdata", rsp_rdata, exp_rd);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("post_rsp", {rsp_valid, cmd_ready, apb_psel}, 3'b010);
  endtask

  task automatic reset_mid_access();
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 5'h0A;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_pre_access", {apb_psel, apb_penable}, 2'b11);
    apb_ares = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_mid_outputs", {apb_psel, apb_penable, rsp_valid}, 3'b000);
    @(negedge clk);
    apb_ares = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("rst_after_release", {cmd_ready, rsp_valid, apb_psel}, 3'b100);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apb_ares = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_ctrl", {cmd_ready, rsp_valid, apb_psel, apb_penable, apb_pwrite, apb_prot, rsp_error},
             7'b1000000);
    check_eq("reset_data", {rsp_rdata, apb_wdata}, 64'd0);
    check_eq("reset_addr", apb_addr, 0);
    apb_ares = 1'b0;
    @(negedge clk);

    run_txn(1'b1, 5'h05, 32'hDEADBEEF, 1'b0, 0, 32'h0BAD0BAD, 1'b0, 0);
    run_txn(1'b0, 5'h11, 32'hCAFEF00D, 1'b1, 2, 32'h12345678, 1'b0, 0);
    run_txn(1'b0, 5'h03, 32'h0, 1'b0, 0, 32'hA5A5A5A5, 1'b1, 0);
    run_txn(1'b1, 5'h1F, 32'h00000001, 1'b0, 1, 32'h0, 1'b0, 0);
    run_txn(1'b0, 5'h07, 32'h0, 1'b0, 100, 32'hFFFFFFFF, 1'b0, 0);
    run_txn(1'b0, 5'h08, 32'h0, 1'b1, TO - 1, 32'h87654321, 1'b0, 0);
    run_txn(1'b0, 5'h09, 32'h0, 1'b0, 1, 32'h55AA55AA, 1'b0, 3);

    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom), AW'($urandom), $urandom, 1'($urandom),
              int'($urandom_range(0, TO + 2)), $urandom, 1'($urandom),
              int'($urandom_range(0, 3)));
    end

    reset_mid_access();
    run_txn(1'b0, 5'h15, 32'h0, 1'b0, 0, 32'h13579BDF, 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
